// File: rtl/lighthouse_ootx_decoder_if.sv
// OOTX decoder bundle: per-sync-pulse bit input and decoded payload/frame status outputs.
interface lighthouse_ootx_decoder_if;
    logic        ootx_bit;
    logic        ootx_strobe;
    logic [7:0]  out_data;
    logic        out_strobe;
    logic        frame_start;
    logic        frame_done;
    logic        crc_ok;
    logic        frame_error;
    logic [15:0] length;

    modport master (
        output ootx_bit, ootx_strobe,
        input  out_data, out_strobe, frame_start, frame_done, crc_ok, frame_error, length
    );

    modport slave (
        input  ootx_bit, ootx_strobe,
        output out_data, out_strobe, frame_start, frame_done, crc_ok, frame_error, length
    );
endinterface

// File: rtl/lighthouse_ootx_decoder.sv
// Lighthouse OOTX frame decoder: preamble hunt, sync-bit stripping, length/payload
// extraction with byte streaming, and trailing CRC-32 check.
module lighthouse_ootx_decoder #(
    parameter int MAX_LEN = 64
) (
    input logic                      clk,
    input logic                      reset,
    lighthouse_ootx_decoder_if.slave bus
);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CRC} state_t;

    state_t      state, state_n;
    logic [4:0]  zero_count, zero_count_n;
    logic [15:0] word, word_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [15:0] word_cnt, word_cnt_n;
    logic [7:0]  byte_idx, byte_idx_n;
    logic [31:0] crc, crc_n;
    logic [15:0] rx_lo, rx_lo_n;
    logic [15:0] emit_word, emit_word_n;
    logic [1:0]  emit_cnt, emit_cnt_n;
    logic [7:0]  out_data_q, out_data_n;
    logic        out_strobe_q, out_strobe_n;
    logic        frame_start_q, frame_start_n;
    logic        frame_done_q, frame_done_n;
    logic        crc_ok_q, crc_ok_n;
    logic        frame_error_q, frame_error_n;
    logic [15:0] length_q, length_n;

    logic [15:0] len_rx;
    logic [15:0] words_needed;
    logic [31:0] rx_crc;

    // Reflected CRC-32/IEEE, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign len_rx       = {word[7:0], word[15:8]};
    assign words_needed = 16'((17'(length_q) + 17'd1) >> 1);
    assign rx_crc       = {word[7:0], word[15:8], rx_lo[7:0], rx_lo[15:8]};

    always_comb begin
        state_n       = state;
        zero_count_n  = zero_count;
        word_n        = word;
        bit_cnt_n     = bit_cnt;
        word_cnt_n    = word_cnt;
        byte_idx_n    = byte_idx;
        crc_n         = crc;
        rx_lo_n       = rx_lo;
        emit_word_n   = emit_word;
        emit_cnt_n    = emit_cnt;
        out_data_n    = out_data_q;
        out_strobe_n  = 1'b0;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        crc_ok_n      = crc_ok_q;
        frame_error_n = 1'b0;
        length_n      = length_q;

        // Byte emission runs between strobes; the pad byte past length is skipped.
        if (emit_cnt != 2'd0) begin
            emit_cnt_n  = emit_cnt - 2'd1;
            emit_word_n = {emit_word[7:0], 8'h00};
            byte_idx_n  = byte_idx + 8'd1;
            if ({8'h00, byte_idx} < length_q) begin
                out_strobe_n = 1'b1;
                out_data_n   = emit_word[15:8];
                crc_n        = crc32_byte(crc, emit_word[15:8]);
            end
        end

        if (bus.ootx_strobe) begin
            if (state == HUNT) begin
                if (!bus.ootx_bit) begin
                    zero_count_n = (zero_count == 5'd17) ? 5'd17 : zero_count + 5'd1;
                end else if (zero_count == 5'd17) begin
                    state_n      = LEN;
                    zero_count_n = 5'd0;
                    bit_cnt_n    = 5'd0;
                    word_cnt_n   = 16'd0;
                    byte_idx_n   = 8'd0;
                    crc_n        = 32'hFFFFFFFF;
                end else begin
                    zero_count_n = 5'd0;
                end
            end else if (bit_cnt != 5'd16) begin
                word_n    = {word[14:0], bus.ootx_bit};
                bit_cnt_n = bit_cnt + 5'd1;
            end else begin
                bit_cnt_n = 5'd0;
                if (!bus.ootx_bit) begin
                    // The bad sync bit is itself a zero toward the next preamble.
                    frame_error_n = 1'b1;
                    state_n       = HUNT;
                    zero_count_n  = 5'd1;
                end else begin
                    case (state)
                        LEN: begin
                            length_n = len_rx;
                            if (len_rx == 16'd0 || len_rx > 16'(MAX_LEN)) begin
                                frame_error_n = 1'b1;
                                state_n       = HUNT;
                                zero_count_n  = 5'd0;
                            end else begin
                                frame_start_n = 1'b1;
                                state_n       = PAYLOAD;
                                word_cnt_n    = 16'd0;
                            end
                        end
                        PAYLOAD: begin
                            emit_word_n = word;
                            emit_cnt_n  = 2'd2;
                            if (word_cnt + 16'd1 == words_needed) begin
                                state_n    = CRC;
                                word_cnt_n = 16'd0;
                            end else begin
                                word_cnt_n = word_cnt + 16'd1;
                            end
                        end
                        default: begin
                            if (word_cnt == 16'd0) begin
                                rx_lo_n    = word;
                                word_cnt_n = 16'd1;
                            end else begin
                                crc_ok_n     = (rx_crc == ~crc);
                                frame_done_n = 1'b1;
                                state_n      = HUNT;
                                zero_count_n = 5'd0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HUNT;
            zero_count    <= 5'd0;
            word          <= 16'd0;
            bit_cnt       <= 5'd0;
            word_cnt      <= 16'd0;
            byte_idx      <= 8'd0;
            crc           <= 32'hFFFFFFFF;
            rx_lo         <= 16'd0;
            emit_word     <= 16'd0;
            emit_cnt      <= 2'd0;
            out_data_q    <= 8'd0;
            out_strobe_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            crc_ok_q      <= 1'b0;
            frame_error_q <= 1'b0;
            length_q      <= 16'd0;
        end else begin
            state         <= state_n;
            zero_count    <= zero_count_n;
            word          <= word_n;
            bit_cnt       <= bit_cnt_n;
            word_cnt      <= word_cnt_n;
            byte_idx      <= byte_idx_n;
            crc           <= crc_n;
            rx_lo         <= rx_lo_n;
            emit_word     <= emit_word_n;
            emit_cnt      <= emit_cnt_n;
            out_data_q    <= out_data_n;
            out_strobe_q  <= out_strobe_n;
            frame_start_q <= frame_start_n;
            frame_done_q  <= frame_done_n;
            crc_ok_q      <= crc_ok_n;
            frame_error_q <= frame_error_n;
            length_q      <= length_n;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_strobe  = out_strobe_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.frame_error = frame_error_q;
    assign bus.length      = length_q;

endmodule

// File: tb/tb_lighthouse_ootx_decoder.sv
// Directed bench for lighthouse_ootx_decoder using the "123456789" CRC-32 frame.
module tb_lighthouse_ootx_decoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lighthouse_ootx_decoder_if bus();

    lighthouse_ootx_decoder #(.MAX_LEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] got[$];
    int n_start, n_done, n_err;

    always @(negedge clk) begin
        if (bus.out_strobe)  got.push_back(bus.out_data);
        if (bus.frame_start) n_start++;
        if (bus.frame_done)  n_done++;
        if (bus.frame_error) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic clear_mon();
        got.delete();
        n_start = 0;
        n_done  = 0;
        n_err   = 0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.ootx_bit    = b;
        bus.ootx_strobe = 1'b1;
        @(negedge clk);
        bus.ootx_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_data16(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_preamble(input int nzeros);
        for (int i = 0; i < nzeros; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    // Length 9, payload "123456789" + pad, CRC words {crc_lo, F4CB}.
    // bad_sync: word index whose sync bit is sent as 0 (then stop); stop_at: send data only, no sync.
    task automatic send_body(input logic [15:0] crc_lo, input int bad_sync, input int stop_at);
        logic [15:0] w[8];
        w[0] = 16'h0900; w[1] = 16'h3132; w[2] = 16'h3334; w[3] = 16'h3536;
        w[4] = 16'h3738; w[5] = 16'h3900; w[6] = crc_lo;  w[7] = 16'hF4CB;
        for (int k = 0; k < 8; k++) begin
            send_data16(w[k]);
            if (k == stop_at) return;
            send_bit(k != bad_sync);
            if (k == bad_sync) return;
        end
    endtask

    task automatic check_outputs_zero(input string t);
        chk({t, "_out_strobe"},  32'(bus.out_strobe),  32'd0);
        chk({t, "_out_data"},    32'(bus.out_data),    32'd0);
        chk({t, "_frame_start"}, 32'(bus.frame_start), 32'd0);
        chk({t, "_frame_done"},  32'(bus.frame_done),  32'd0);
        chk({t, "_crc_ok"},      32'(bus.crc_ok),      32'd0);
        chk({t, "_frame_error"}, 32'(bus.frame_error), 32'd0);
        chk({t, "_length"},      32'(bus.length),      32'd0);
    endtask

    task automatic check_bytes(input string t, input int n);
        chk({t, "_nbytes"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) chk({t, "_byte"}, 32'(got[i]), 32'(8'h31 + i));
    endtask

    task automatic check_good(input string t, input logic exp_crc);
        chk({t, "_starts"}, 32'(n_start), 32'd1);
        check_bytes(t, 9);
        chk({t, "_length"}, 32'(bus.length), 32'd9);
        chk({t, "_dones"},  32'(n_done), 32'd1);
        chk({t, "_crc_ok"}, 32'(bus.crc_ok), 32'(exp_crc));
        chk({t, "_errors"}, 32'(n_err), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.ootx_bit = 1'b0;
        bus.ootx_strobe = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Clean frame
        clear_mon();
        send_preamble(17);
        send_body(16'h2639, -1, -1);
        repeat (10) @(negedge clk);
        check_good("clean", 1'b1);

        // Corrupted CRC word
        clear_mon();
        send_preamble(17);
        send_body(16'h2638, -1, -1);
        repeat (10) @(negedge clk);
        check_good("badcrc", 1'b0);

        // Sync error after payload word 2, then a clean frame
        clear_mon();
        send_preamble(17);
        send_body(16'h2639, 2, -1);
        repeat (10) @(negedge clk);
        chk("sync_err_pulses", 32'(n_err), 32'd1);
        check_bytes("sync_err", 2);
        chk("sync_err_dones", 32'(n_done), 32'd0);
        clear_mon();
        send_preamble(17);
        send_body(16'h2639, -1, -1);
        repeat (10) @(negedge clk);
        check_good("after_sync_err", 1'b1);

        // Short preamble must not lock
        clear_mon();
        send_preamble(16);
        send_body(16'h2639, -1, -1);
        repeat (10) @(negedge clk);
        chk("short_pre_starts", 32'(n_start), 32'd0);
        chk("short_pre_nbytes", 32'(got.size()), 32'd0);
        chk("short_pre_dones",  32'(n_done), 32'd0);
        clear_mon();
        send_preamble(17);
        send_body(16'h2639, -1, -1);
        repeat (10) @(negedge clk);
        check_good("after_short_pre", 1'b1);

        // Oversize length, then a long zero run before the preamble 1
        clear_mon();
        send_preamble(17);
        send_data16(16'hFF00);
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        chk("biglen_err",    32'(n_err), 32'd1);
        chk("biglen_starts", 32'(n_start), 32'd0);
        chk("biglen_nbytes", 32'(got.size()), 32'd0);
        chk("biglen_length", 32'(bus.length), 32'd255);
        clear_mon();
        send_preamble(30);
        send_body(16'h2639, -1, -1);
        repeat (10) @(negedge clk);
        check_good("long_zero_run", 1'b1);

        // Reset while the 5th payload byte is pending
        clear_mon();
        send_preamble(17);
        send_body(16'h2639, -1, 3);
        @(negedge clk);
        bus.ootx_bit    = 1'b1;
        bus.ootx_strobe = 1'b1;
        @(negedge clk);
        bus.ootx_strobe = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_bytes("midreset", 4);
        clear_mon();
        send_preamble(17);
        send_body(16'h2639, -1, -1);
        repeat (10) @(negedge clk);
        check_good("after_reset", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
